// File: rtl/pb_reset_filter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pb_reset_filter_if                                           |
// | Brief   : Signal bundle between the push-button conditioner and its    |
// |           consumers (raw button in, debounced level/strobes and the    |
// |           long-hold reset request out).                                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface pb_reset_filter_if;
  logic PB;         // raw board button, asynchronous, active-low
  logic pb_lvl;     // debounced level, 1 = pressed
  logic pb_rise;    // one-cycle strobe on accepted press
  logic pb_fall;    // one-cycle strobe on accepted release
  logic long_hold;  // high from long-hold detection until accepted release
  logic RST_n_req;  // active-low reset request pulse

  // Conditioner side: consumes the raw button, produces the clean outputs.
  modport master (
    input  PB,
    output pb_lvl,
    output pb_rise,
    output pb_fall,
    output long_hold,
    output RST_n_req
  );

  // Board/consumer side: drives the raw button, observes the outputs.
  modport slave (
    output PB,
    input  pb_lvl,
    input  pb_rise,
    input  pb_fall,
    input  long_hold,
    input  RST_n_req
  );
endinterface
`default_nettype wire

// File: rtl/pb_reset_filter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pb_reset_filter                                              |
// | Brief   : Push-button conditioner ahead of the reset synchronizer.     |
// |           Two-flop synchronizer, press/release debounce FSM with       |
// |           strobes, and optional long-hold to reset-request pulse.      |
// | Config  : define PB_LONG_PRESS_EN to build the hold counter,          |
// |           long_hold flag and RST_n_req pulse generator; otherwise      |
// |           long_hold is tied 0 and RST_n_req tied 1.                    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module pb_reset_filter #(
  parameter int DB_CYCLES   = 50000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int RST_PULSE   = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pb_reset_filter_if.master pb
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  logic            sync1_q, sync2_q;
  logic            pb_s;
  state_t          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pb_lvl_q, pb_lvl_d;
  logic            pb_rise_q, pb_rise_d;
  logic            pb_fall_q, pb_fall_d;

  // Bring the asynchronous button into clk; both stages rest at "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pb.PB;
      sync2_q <= sync1_q;
    end
  end

  // Active-high pressed indication after synchronization.
  assign pb_s = ~sync2_q;

  // Debounce state, counter and registered level/strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      pb_lvl_q  <= 1'b0;
      pb_rise_q <= 1'b0;
      pb_fall_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      pb_lvl_q  <= pb_lvl_d;
      pb_rise_q <= pb_rise_d;
      pb_fall_q <= pb_fall_d;
    end
  end

  // Debounce next-state: a press or release is accepted only after the
  // synchronized level has held for DB_CYCLES consecutive cycles.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    pb_lvl_d  = pb_lvl_q;
    pb_rise_d = 1'b0;
    pb_fall_d = 1'b0;
    case (state_q)
      IDLE: begin
        pb_lvl_d = 1'b0;
        if (pb_s) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!pb_s) begin
          // Bounce: drop back silently.
          state_d = IDLE;
        end else if (db_cnt_q == DB_MAX) begin
          state_d   = HELD;
          pb_lvl_d  = 1'b1;
          pb_rise_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pb_s) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end
      end
      REL_DB: begin
        if (pb_s) begin
          // Release glitch: still pressed, hold timing carries on.
          state_d = HELD;
        end else if (db_cnt_q == DB_MAX) begin
          state_d   = IDLE;
          pb_lvl_d  = 1'b0;
          pb_fall_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pb.pb_lvl  = pb_lvl_q;
  assign pb.pb_rise = pb_rise_q;
  assign pb.pb_fall = pb_fall_q;

`ifdef PB_LONG_PRESS_EN
  localparam int HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int PULSE_W = $clog2(RST_PULSE + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LEN = PULSE_W'(RST_PULSE);

  logic               hold_active;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               long_hold_q, long_hold_d;
  logic               lh_set_q, lh_set_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic               rst_n_req_q, rst_n_req_d;

  // Hold time accrues while pressed, including during a release debounce.
  assign hold_active = (state_q == HELD) || (state_q == REL_DB);

  // Hold counter, long-hold flag and reset-request pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      long_hold_q <= 1'b0;
      lh_set_q    <= 1'b0;
      pulse_cnt_q <= '0;
      rst_n_req_q <= 1'b1;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      long_hold_q <= long_hold_d;
      lh_set_q    <= lh_set_d;
      pulse_cnt_q <= pulse_cnt_d;
      rst_n_req_q <= rst_n_req_d;
    end
  end

  // Hold/pulse next-state: a release accepted on the same edge wins over
  // setting long_hold; a pulse already loaded always runs to completion.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    long_hold_d = long_hold_q;
    lh_set_d    = 1'b0;
    pulse_cnt_d = pulse_cnt_q;

    if (pb_rise_d) begin
      hold_cnt_d = '0;
    end else if (hold_active && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    if (pb_fall_d) begin
      long_hold_d = 1'b0;
    end else if (hold_active && (hold_cnt_q == HOLD_MAX) && !long_hold_q) begin
      long_hold_d = 1'b1;
      lh_set_d    = 1'b1;
    end

    if (lh_set_q) begin
      pulse_cnt_d = PULSE_LEN;
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_d = pulse_cnt_q - 1'b1;
    end

    rst_n_req_d = (pulse_cnt_d == '0);
  end

  assign pb.long_hold = long_hold_q;
  assign pb.RST_n_req = rst_n_req_q;
`else
  assign pb.long_hold = 1'b0;
  assign pb.RST_n_req = 1'b1;
`endif

endmodule
`default_nettype wire
